// File: rtl/mux3_rr_arbiter.sv
// Round-robin arbiter sharing one 24-bit datapath between three requesters.
// Holds each grant until done or hold timeout; parks the mux on code 2'b11 when idle.
module mux3_rr_arbiter #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic [2:0] req_i,
    input  logic       done_i,
    output logic [2:0] gnt_o,
    output logic [1:0] sel_o,
    output logic       start_o,
    output logic       busy_o,
    output logic       timeout_o
);

    localparam int unsigned CW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam bit          TO_EN = (MAX_HOLD > 0);
    localparam logic [CW-1:0] HOLD_MAX  = CW'(MAX_HOLD);
    localparam logic [CW-1:0] HOLD_LAST = (MAX_HOLD > 0) ? CW'(MAX_HOLD - 1) : '0;
    localparam logic [1:0]  SEL_IDLE = 2'b11;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t        state_q, state_d;
    logic [2:0]    gnt_q, gnt_d;
    logic [1:0]    sel_q, sel_d;
    logic          start_q, start_d;
    logic          timeout_q, timeout_d;
    logic [CW-1:0] hold_q, hold_d;
    logic [1:0]    last_q, last_d;

    logic [2:0]    arb_req;
    logic          arb_any;
    logic [1:0]    p0, p1, p2;
    logic [1:0]    win;
    logic          timeout_hit;

    // Rotating priority order: the requester after last comes first, last comes last.
    always_comb begin
        p0 = 2'd0;
        p1 = 2'd1;
        p2 = 2'd2;
        case (last_q)
            2'd0: begin p0 = 2'd1; p1 = 2'd2; p2 = 2'd0; end
            2'd1: begin p0 = 2'd2; p1 = 2'd0; p2 = 2'd1; end
            default: begin p0 = 2'd0; p1 = 2'd1; p2 = 2'd2; end
        endcase
    end

    always_comb begin
        arb_req = (state_q == GRANT) ? (req_i & ~gnt_q) : req_i;
        arb_any = |arb_req;
        if (arb_req[p0])      win = p0;
        else if (arb_req[p1]) win = p1;
        else                  win = p2;
    end

    assign timeout_hit = TO_EN && (hold_q == HOLD_LAST);

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        sel_d     = sel_q;
        start_d   = 1'b0;
        timeout_d = 1'b0;
        hold_d    = hold_q;
        last_d    = last_q;
        case (state_q)
            IDLE: begin
                if (arb_any) begin
                    state_d = GRANT;
                    gnt_d   = 3'b001 << win;
                    sel_d   = win;
                    start_d = 1'b1;
                    hold_d  = '0;
                    last_d  = win;
                end
            end
            GRANT: begin
                if (done_i) begin
                    // Hand straight over to another pending requester, no idle bubble.
                    if (arb_any) begin
                        gnt_d   = 3'b001 << win;
                        sel_d   = win;
                        start_d = 1'b1;
                        hold_d  = '0;
                        last_d  = win;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = 3'b000;
                        sel_d   = SEL_IDLE;
                        hold_d  = '0;
                    end
                end else if (timeout_hit) begin
                    state_d   = IDLE;
                    gnt_d     = 3'b000;
                    sel_d     = SEL_IDLE;
                    timeout_d = 1'b1;
                    hold_d    = '0;
                end else if (hold_q != HOLD_MAX) begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 3'b000;
                sel_d   = SEL_IDLE;
                hold_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            gnt_q     <= 3'b000;
            sel_q     <= SEL_IDLE;
            start_q   <= 1'b0;
            timeout_q <= 1'b0;
            hold_q    <= '0;
            last_q    <= 2'd2;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            sel_q     <= sel_d;
            start_q   <= start_d;
            timeout_q <= timeout_d;
            hold_q    <= hold_d;
            last_q    <= last_d;
        end
    end

    assign gnt_o     = gnt_q;
    assign sel_o     = sel_q;
    assign start_o   = start_q;
    assign busy_o    = (state_q == GRANT);
    assign timeout_o = timeout_q;

endmodule
